// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column strobes, synchronized row sampling,
// press/release debounce, and one key code per press over a valid/ready handshake.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun
);
    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t          state, state_d;
    logic [1:0]      col_idx, col_d, row_idx, row_d, low_row;
    logic [DW-1:0]   deb_cnt, deb_d;
    logic [DIVW-1:0] div;
    logic [3:0]      row_m, row_s, emit_code;
    logic            tick, emit, xfer, hit, deb_done;

    assign tick      = (div == DIVW'(SCAN_DIV - 1));
    assign xfer      = key_valid & key_ready;
    assign hit       = row_s[row_idx];
    assign deb_done  = ((deb_cnt + DW'(1)) == DW'(DEBOUNCE_SCANS));
    assign emit_code = {row_d, col_idx};
    assign col_out   = en ? (4'b0001 << col_idx) : 4'b0000;

    // Lowest active row wins when several rows answer the same column.
    always_comb begin
        low_row = 2'd3;
        if (row_s[0])      low_row = 2'd0;
        else if (row_s[1]) low_row = 2'd1;
        else if (row_s[2]) low_row = 2'd2;
    end

    always_comb begin
        state_d = state;
        col_d   = col_idx;
        row_d   = row_idx;
        deb_d   = deb_cnt;
        emit    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s == 4'b0000) begin
                        col_d = col_idx + 2'd1;
                    end else begin
                        row_d = low_row;
                        if (DEBOUNCE_SCANS == 1) begin
                            emit    = 1'b1;
                            state_d = HELD;
                            deb_d   = '0;
                        end else begin
                            state_d = DEBOUNCE;
                            deb_d   = DW'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!hit) begin
                        state_d = SCAN;
                        col_d   = col_idx + 2'd1;
                        deb_d   = '0;
                    end else if (deb_done) begin
                        emit    = 1'b1;
                        state_d = HELD;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    // Any bounce back to pressed restarts the release count.
                    if (hit) begin
                        deb_d = '0;
                    end else if (deb_done) begin
                        state_d = SCAN;
                        col_d   = col_idx + 2'd1;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_cnt + DW'(1);
                    end
                end
                default: begin
                    state_d = SCAN;
                    deb_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_m     <= '0;
            row_s     <= '0;
            div       <= '0;
            state     <= SCAN;
            col_idx   <= '0;
            row_idx   <= '0;
            deb_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (!en) begin
            row_m     <= '0;
            row_s     <= '0;
            div       <= '0;
            state     <= SCAN;
            col_idx   <= '0;
            row_idx   <= '0;
            deb_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            row_m   <= row_in;
            row_s   <= row_m;
            div     <= tick ? '0 : div + DIVW'(1);
            state   <= state_d;
            col_idx <= col_d;
            row_idx <= row_d;
            deb_cnt <= deb_d;
            // A transfer in the emit cycle frees the slot for the new key.
            if (emit && (!key_valid || xfer)) begin
                key_code  <= emit_code;
                key_valid <= 1'b1;
            end else begin
                if (emit) overrun   <= 1'b1;
                if (xfer) key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: a physical keypad matrix drives the rows
// and a tick-level behavioural model predicts every visible output each cycle.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DN = 3;

    logic       clk = 1'b0;
    logic       nrst, en, key_ready, key_valid, overrun;
    logic [3:0] row_in, col_out, key_code;
    logic [3:0] keys [4];

    always #5 clk = ~clk;

    // Keypad physics: a row sees a pressed key only while its column is strobed.
    always_comb begin
        row_in = 4'b0000;
        for (int r = 0; r < 4; r++) row_in[r] = |(keys[r] & col_out);
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DN)) dut (
        .clk(clk), .nrst(nrst), .en(en), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;

    int         m_div, m_col, m_mode, m_row, m_cnt;
    logic       m_valid, m_ovr;
    logic [3:0] m_code;
    logic [3:0] xfers [$];
    bit         rand_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_div = 0; m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0;
        m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'h0;
    endfunction

    function automatic logic [3:0] col_rows(input int c);
        logic [3:0] v;
        for (int r = 0; r < 4; r++) v[r] = keys[r][c];
        return v;
    endfunction

    function automatic logic [3:0] exp_col();
        logic [3:0] one;
        one = 4'b0001;
        return en ? (one << m_col) : 4'b0000;
    endfunction

    // mode 0: hunting for a key, 1: confirming a press, 2: waiting for release
    function automatic void model_clock();
        logic [3:0] rows, code;
        bit emit, xfer;
        if (!nrst || !en) begin
            m_reset();
            return;
        end
        emit = 0;
        code = 4'h0;
        xfer = m_valid && key_ready;
        if (m_div == SD - 1) begin
            rows = col_rows(m_col);
            if (m_mode == 0) begin
                if (rows == 4'b0000) m_col = (m_col + 1) % 4;
                else begin
                    for (int r = 3; r >= 0; r--) if (rows[r]) m_row = r;
                    m_cnt  = 1;
                    m_mode = 1;
                    if (m_cnt == DN) begin emit = 1; m_mode = 2; m_cnt = 0; end
                end
            end else if (m_mode == 1) begin
                if (rows[m_row]) begin
                    m_cnt++;
                    if (m_cnt == DN) begin emit = 1; m_mode = 2; m_cnt = 0; end
                end else begin
                    m_mode = 0; m_col = (m_col + 1) % 4; m_cnt = 0;
                end
            end else begin
                if (rows[m_row]) m_cnt = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == DN) begin m_mode = 0; m_col = (m_col + 1) % 4; m_cnt = 0; end
                end
            end
            code = 4'(m_row * 4 + m_col);
        end
        m_div = (m_div + 1) % SD;
        if (emit) begin
            if (!m_valid || xfer) begin m_code = code; m_valid = 1'b1; end
            else m_ovr = 1'b1;
        end else if (xfer) m_valid = 1'b0;
    endfunction

    task automatic step();
        if (rand_ready) key_ready = ($urandom_range(0, 2) != 0);
        if (nrst && en && key_valid && key_ready) xfers.push_back(key_code);
        model_clock();
        @(posedge clk);
        #1;
        chk("outputs", {col_out, key_valid, key_code, overrun}, {exp_col(), m_valid, m_code, m_ovr});
    endtask

    task automatic run_ticks(input int n);
        repeat (n * SD) step();
    endtask

    task automatic align();
        while (m_div != 0) step();
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
    endtask

    initial begin
        int n0, k, guard;
        bit found;
        nrst = 1'b0; en = 1'b0; key_ready = 1'b1; rand_ready = 0;
        release_all();
        m_reset();
        #1;
        chk("reset_en_low", {col_out, key_valid, key_code, overrun}, 10'b0000_0_0000_0);
        en = 1'b1;
        #1;
        chk("reset_col", {col_out, key_valid, key_code, overrun}, 10'b0001_0_0000_0);
        en = 1'b0;
        repeat (2) step();
        nrst = 1'b1;
        repeat (2) step();

        // Idle scanning
        en = 1'b1;
        n0 = xfers.size();
        repeat (64) step();
        chk("idle_no_key", xfers.size() - n0, 0);

        // Single press at row1,col2 held ~60 clk
        align();
        n0 = xfers.size();
        keys[1][2] = 1'b1;
        repeat (60) step();
        release_all();
        run_ticks(10);
        chk("single_count", xfers.size() - n0, 1);
        if (xfers.size() > n0) chk("single_code", xfers[$], 4'h6);

        // One-tick bounce in col0
        guard = 0;
        while (!(m_col == 0 && m_div == 0) && guard < 64) begin step(); guard++; end
        chk("bounce_align", guard < 64, 1);
        n0 = xfers.size();
        keys[0][0] = 1'b1;
        repeat (SD) step();
        release_all();
        repeat (SD) step();
        chk("bounce_col", col_out, 4'b0010);
        run_ticks(4);
        chk("bounce_no_key", xfers.size() - n0, 0);

        // Overrun with consumer stalled
        key_ready = 1'b0;
        align();
        keys[3][0] = 1'b1; run_ticks(12); release_all(); run_ticks(6);
        keys[0][1] = 1'b1; run_ticks(12); release_all(); run_ticks(6);
        chk("ovr_code", key_code, 4'hC);
        chk("ovr_valid", key_valid, 1);
        chk("ovr_flag", overrun, 1);
        key_ready = 1'b1;
        step();
        chk("ovr_drain", key_valid, 0);
        chk("ovr_sticky", overrun, 1);

        // en low clears, then emit coinciding with a transfer
        en = 1'b0; repeat (2) step();
        chk("en_clear", {col_out, key_valid, key_code, overrun}, 10'b0000_0_0000_0);
        en = 1'b1; key_ready = 1'b0;
        keys[2][3] = 1'b1;
        guard = 0;
        while (!m_valid && guard < 200) begin step(); guard++; end
        release_all();
        run_ticks(6);
        keys[1][1] = 1'b1;
        found = 0;
        guard = 0;
        while (!found && guard < 200) begin
            key_ready = (m_div == SD - 1 && m_mode == 1 && m_cnt == DN - 1 && keys[m_row][m_col]);
            found = key_ready;
            step();
            guard++;
        end
        key_ready = 1'b0;
        chk("sim_found", found, 1);
        chk("sim_valid", key_valid, 1);
        chk("sim_code", key_code, 4'h5);
        chk("sim_ovr", overrun, 0);
        if (xfers.size() > 0) chk("sim_prev_xfer", xfers[$], 4'hB);
        release_all();
        key_ready = 1'b1;
        run_ticks(8);

        // Async reset while confirming a press; key stays held through it
        align();
        keys[2][1] = 1'b1;
        guard = 0;
        while (m_mode != 1 && guard < 100) begin step(); guard++; end
        chk("rst_in_debounce", m_mode, 1);
        #2 nrst = 1'b0;
        #1;
        chk("async_reset", {col_out, key_valid, key_code, overrun}, 10'b0001_0_0000_0);
        m_reset();
        n0 = xfers.size();
        step();
        #2 nrst = 1'b1;
        run_ticks(12);
        chk("rst_repress_count", xfers.size() - n0, 1);
        if (xfers.size() > n0) chk("rst_repress_code", xfers[$], 4'h9);
        release_all();
        run_ticks(6);

        // Random presses with random consumer back-pressure
        rand_ready = 1;
        repeat (30) begin
            align();
            k = $urandom_range(0, 15);
            keys[k / 4][k % 4] = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 15);
                keys[k / 4][k % 4] = 1'b1;
            end
            run_ticks($urandom_range(1, 20));
            release_all();
            run_ticks($urandom_range(0, 10));
        end
        rand_ready = 0;
        key_ready = 1'b1;
        run_ticks(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
